alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Initiator side of the ALU operand port. Accepts one ALU operation per request handshake and drives CMD/MODE/CIN/OPA/OPB/INP_VALID/CE toward the ALU.
- Operands go out either together (INP_VALID=11) or split across two phases (01 then 10, or 10 then 01), with a programmable gap between the phases.
- Waits the command-dependent result latency, samples the ALU result/flag outputs and returns them on a response handshake.
- Used by the operand sequencer and as the active driver in the ALU bench.

Parameters:
- DW, 8, operand width.
- CW, 4, command width.
- RES_LAT, 1, cycles from last operand phase to a valid result for single-cycle commands.
- MUL_LAT, 3, cycles from last operand phase to a valid result for MODE=1 with CMD 9 or 10.
- TIMEOUT, 16, gap (cycles) at or above which the ALU is expected to flag ERR.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request.
- req_cmd  in  CW  ALU command.
- req_mode  in  1  1=arithmetic, 0=logic.
- req_cin  in  1  carry in.
- req_opa  in  DW  operand A.
- req_opb  in  DW  operand B.
- req_split  in  2  00=both together, 01=A first then B, 10=B first then A, 11=treated as 00.
- req_gap  in  5  idle cycles between the two phases of a split.
- CE  out  1  ALU clock enable.
- INP_VALID  out  2  operand-valid code to ALU.
- OPA, OPB  out  DW  operands.
- CIN  out  1  carry in to ALU.
- CMD  out  CW  command to ALU.
- MODE  out  1  mode to ALU.
- RES  in  DW+2  ALU result.
- COUT, OFLOW, G, E, L, ERR  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_res  out  DW+2  captured result.
- rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err  out  1 each  captured flags.
- rsp_late  out  1  split gap was >= TIMEOUT.

Behaviour:
- Reset (RST=0 at a CLK edge):
  - state=IDLE; req_ready=1; rsp_valid=0; CE=0; INP_VALID=00.
  - OPA/OPB/CMD/MODE/CIN=0.
  - All rsp_* outputs 0.
  - Reset mid-operation abandons the operation; no response is produced.
- States: IDLE, PH1, GAP, PH2, WAIT, RESP.
- IDLE:
  - req_ready=1. A transfer occurs when req_valid && req_ready.
  - On transfer, register the request and go to PH1; req_ready=0 from the next cycle until return to IDLE.
- PH1 (1 cycle):
  - CE=1; CMD/MODE/CIN driven from the registered request.
  - split 00/11: INP_VALID=11, OPA and OPB driven, next state WAIT.
  - split 01: INP_VALID=01, OPA driven, next state GAP.
  - split 10: INP_VALID=10, OPB driven, next state GAP.
- GAP:
  - INP_VALID=00, CE=1, counter runs req_gap cycles, then PH2.
  - req_gap=0 skips GAP: PH2 immediately follows PH1.
- PH2 (1 cycle):
  - Drive the other operand with the complementary code (10 or 01); CMD/MODE/CIN re-driven unchanged.
  - Next state WAIT.
- WAIT:
  - INP_VALID=00, CE=1.
  - Latency L = MUL_LAT if MODE=1 and CMD is 9 or 10, else RES_LAT.
  - Sample RES and the flags on the L-th edge after the last operand phase, then go to RESP.
- Capture rules:
  - Each flag input is recorded as 1 only if it equals 1'b1; z or x is recorded as 0.
  - RES bits that are z or x are recorded as 0.
- rsp_late: set when split!=00/11 and req_gap >= TIMEOUT; otherwise 0.
- RESP:
  - rsp_valid=1 with all rsp_* fields held stable until rsp_valid && rsp_ready, then go to IDLE.
  - CE=0 in RESP and IDLE.
  - rsp_ready held high beforehand completes the response in exactly 1 cycle.
- Backpressure: the next request is not accepted until the response completes. There is no pipelining; one operation is in flight.
- Outputs are registered; OPA/OPB hold their last driven values when not valid.

Decomposition:
- Package alu_issue_pkg holds:
  - the state enum;
  - split encodings;
  - the command constants (CMD_MUL=9, CMD_SHLSUB=10);
  - a latency function (mode, cmd) -> cycles.
- One sub-module, alu_rsp_capture: z/x-to-0 sanitising and the result/flag holding register.

Test Plan:
- Request mode=1, cmd=0, opa=8'h0A, opb=8'h05, split=00 -> INP_VALID=11 for 1 cycle; rsp_res=15, rsp_cout=0, rsp_valid 1 cycle after the operand phase plus RES_LAT.
- Request mode=1, cmd=9, opa=3, opb=4, split=01, gap=2 -> INP_VALID sequence 01,00,00,10; response after MUL_LAT with rsp_res=20; rsp_late=0.
- Request mode=0, cmd=0, opa=8'hF0, opb=8'h3C, split=10, gap=0 -> INP_VALID 10 then 01 back-to-back; rsp_res=10'h030.
- Request split=01, gap=17, mode=1, cmd=8, opa=opb=7 -> rsp_late=1, rsp_e=1, rsp_g=0, rsp_l=0 (z inputs captured as 0).
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0 throughout; completes on the rsp_ready cycle.
- Assert RST=0 during GAP -> next cycle INP_VALID=00, CE=0, req_ready=1, no rsp_valid; a new request then completes normally.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types, encodings and the result-latency helper for the ALU op issuer.
package alu_issue_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_GAP,
    ST_PH2,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SPLIT_BOTH     = 2'b00,
    SPLIT_A_FIRST  = 2'b01,
    SPLIT_B_FIRST  = 2'b10,
    SPLIT_BOTH_ALT = 2'b11
  } split_e;

  // INP_VALID codes: bit 0 qualifies OPA, bit 1 qualifies OPB
  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

  localparam int CMD_MAX_W = 8;
  localparam int LAT_W     = 4;

  localparam logic [CMD_MAX_W-1:0] CMD_MUL    = 8'd9;
  localparam logic [CMD_MAX_W-1:0] CMD_SHLSUB = 8'd10;

  // 11 is an alias for "both operands together"
  function automatic split_e normalize_split(input logic [1:0] raw);
    split_e s;
    s = split_e'(raw);
    if (s == SPLIT_BOTH_ALT) s = SPLIT_BOTH;
    return s;
  endfunction

  // Cycles from the last operand phase to a valid ALU result
  function automatic logic [LAT_W-1:0] op_latency(input logic                 mode,
                                                  input logic [CMD_MAX_W-1:0] cmd,
                                                  input int                   res_lat,
                                                  input int                   mul_lat);
    if (mode && (cmd == CMD_MUL || cmd == CMD_SHLSUB)) return LAT_W'(mul_lat);
    return LAT_W'(res_lat);
  endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// Request/response handshake bundle between an operation source and the issuer.
interface alu_op_issuer_if #(
  parameter int DW = 8,
  parameter int CW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_cmd;
  logic          req_mode;
  logic          req_cin;
  logic [DW-1:0] req_opa;
  logic [DW-1:0] req_opb;
  logic [1:0]    req_split;
  logic [4:0]    req_gap;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW+1:0] rsp_res;
  logic          rsp_cout;
  logic          rsp_oflow;
  logic          rsp_g;
  logic          rsp_e;
  logic          rsp_l;
  logic          rsp_err;
  logic          rsp_late;

  modport master (
    output req_valid, req_cmd, req_mode, req_cin, req_opa, req_opb, req_split, req_gap,
    input  req_ready,
    input  rsp_valid, rsp_res, rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err, rsp_late,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_cmd, req_mode, req_cin, req_opa, req_opb, req_split, req_gap,
    output req_ready,
    output rsp_valid, rsp_res, rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err, rsp_late,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_rsp_capture.sv
// Samples the ALU result and flags, forcing any bit that is not a solid 1 to 0,
// and holds them until the next capture.
module alu_rsp_capture #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          capture_en,
  input  logic          late_in,
  input  logic [DW+1:0] res_in,
  input  logic [5:0]    flags_in,
  output logic [DW+1:0] res_out,
  output logic [5:0]    flags_out,
  output logic          late_out
);

  logic [DW+1:0] res_clean, res_q, res_d;
  logic [5:0]    flags_clean, flags_q, flags_d;
  logic          late_q, late_d;

  // Map 0, x and z alike to 0 so floating ALU outputs read as cleared
  always_comb begin
    res_clean   = '0;
    flags_clean = '0;
    for (int i = 0; i < DW + 2; i++) res_clean[i] = (res_in[i] === 1'b1);
    for (int i = 0; i < 6; i++) flags_clean[i] = (flags_in[i] === 1'b1);
  end

  // Load on capture, otherwise hold
  always_comb begin
    res_d   = res_q;
    flags_d = flags_q;
    late_d  = late_q;
    if (capture_en) begin
      res_d   = res_clean;
      flags_d = flags_clean;
      late_d  = late_in;
    end
  end

  // Holding register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      res_q   <= '0;
      flags_q <= '0;
      late_q  <= 1'b0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
      late_q  <= late_d;
    end
  end

  assign res_out   = res_q;
  assign flags_out = flags_q;
  assign late_out  = late_q;

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one ALU operation per request (operands together or split with a gap),
// waits the command latency, captures the result and returns it on a response.
//
// state   | meaning
// IDLE    | ready for a request, ALU disabled
// PH1     | first (or only) operand phase
// GAP     | idle cycles between split operand phases
// PH2     | second operand phase of a split
// WAIT    | counting down to the result-valid cycle
// RESP    | response presented until accepted
module alu_op_issuer
  import alu_issue_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int RES_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int TIMEOUT = 16
) (
  input  logic           CLK,
  input  logic           RST,
  alu_op_issuer_if.slave bus,
  output logic           CE,
  output logic [1:0]     INP_VALID,
  output logic [DW-1:0]  OPA,
  output logic [DW-1:0]  OPB,
  output logic           CIN,
  output logic [CW-1:0]  CMD,
  output logic           MODE,
  input  logic [DW+1:0]  RES,
  input  logic           COUT,
  input  logic           OFLOW,
  input  logic           G,
  input  logic           E,
  input  logic           L,
  input  logic           ERR
);

  state_e            state_q, state_d;

  logic [CW-1:0]     rq_cmd_q, rq_cmd_d;
  logic              rq_mode_q, rq_mode_d;
  logic              rq_cin_q, rq_cin_d;
  logic [DW-1:0]     rq_opa_q, rq_opa_d;
  logic [DW-1:0]     rq_opb_q, rq_opb_d;
  split_e            rq_split_q, rq_split_d;
  logic [4:0]        rq_gap_q, rq_gap_d;
  logic              rq_late_q, rq_late_d;

  logic [4:0]        gap_cnt_q, gap_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0]  op_lat;
  logic              capture_en;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ce_q, ce_d;
  logic [1:0]        inp_valid_q, inp_valid_d;
  logic [DW-1:0]     opa_q, opa_d;
  logic [DW-1:0]     opb_q, opb_d;
  logic [CW-1:0]     cmd_q, cmd_d;
  logic              mode_q, mode_d;
  logic              cin_q, cin_d;

  logic [5:0]        cap_flags;

  assign op_lat = op_latency(rq_mode_q, CMD_MAX_W'(rq_cmd_q), RES_LAT, MUL_LAT);

  // Next state, request capture and the gap/latency down-counters
  always_comb begin
    state_d    = state_q;
    rq_cmd_d   = rq_cmd_q;
    rq_mode_d  = rq_mode_q;
    rq_cin_d   = rq_cin_q;
    rq_opa_d   = rq_opa_q;
    rq_opb_d   = rq_opb_q;
    rq_split_d = rq_split_q;
    rq_gap_d   = rq_gap_q;
    rq_late_d  = rq_late_q;
    gap_cnt_d  = gap_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    capture_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          rq_cmd_d   = bus.req_cmd;
          rq_mode_d  = bus.req_mode;
          rq_cin_d   = bus.req_cin;
          rq_opa_d   = bus.req_opa;
          rq_opb_d   = bus.req_opb;
          rq_split_d = normalize_split(bus.req_split);
          rq_gap_d   = bus.req_gap;
          rq_late_d  = (normalize_split(bus.req_split) != SPLIT_BOTH) &&
                       (int'(bus.req_gap) >= TIMEOUT);
          state_d    = ST_PH1;
        end
      end
      ST_PH1: begin
        if (rq_split_q == SPLIT_BOTH) begin
          state_d   = ST_WAIT;
          lat_cnt_d = op_lat;
        end else if (rq_gap_q == 5'd0) begin
          state_d = ST_PH2;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = rq_gap_q;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= 5'd1) state_d = ST_PH2;
        else gap_cnt_d = gap_cnt_q - 5'd1;
      end
      ST_PH2: begin
        state_d   = ST_WAIT;
        lat_cnt_d = op_lat;
      end
      ST_WAIT: begin
        if (lat_cnt_q <= LAT_W'(1)) begin
          state_d    = ST_RESP;
          capture_en = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU-side and handshake outputs for the cycle described by state_d
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    ce_d        = (state_d inside {ST_PH1, ST_GAP, ST_PH2, ST_WAIT});
    inp_valid_d = IV_NONE;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cmd_d       = cmd_q;
    mode_d      = mode_q;
    cin_d       = cin_q;
    if (state_d == ST_PH1 || state_d == ST_PH2) begin
      cmd_d  = rq_cmd_d;
      mode_d = rq_mode_d;
      cin_d  = rq_cin_d;
    end
    if (state_d == ST_PH1) begin
      case (rq_split_d)
        SPLIT_A_FIRST: begin
          inp_valid_d = IV_A;
          opa_d       = rq_opa_d;
        end
        SPLIT_B_FIRST: begin
          inp_valid_d = IV_B;
          opb_d       = rq_opb_d;
        end
        default: begin
          inp_valid_d = IV_AB;
          opa_d       = rq_opa_d;
          opb_d       = rq_opb_d;
        end
      endcase
    end else if (state_d == ST_PH2) begin
      case (rq_split_d)
        SPLIT_A_FIRST: begin
          inp_valid_d = IV_B;
          opb_d       = rq_opb_d;
        end
        SPLIT_B_FIRST: begin
          inp_valid_d = IV_A;
          opa_d       = rq_opa_d;
        end
        default: inp_valid_d = IV_NONE;
      endcase
    end
  end

  // State, request and output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      rq_cmd_q    <= '0;
      rq_mode_q   <= 1'b0;
      rq_cin_q    <= 1'b0;
      rq_opa_q    <= '0;
      rq_opb_q    <= '0;
      rq_split_q  <= SPLIT_BOTH;
      rq_gap_q    <= '0;
      rq_late_q   <= 1'b0;
      gap_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      ce_q        <= 1'b0;
      inp_valid_q <= IV_NONE;
      opa_q       <= '0;
      opb_q       <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rq_cmd_q    <= rq_cmd_d;
      rq_mode_q   <= rq_mode_d;
      rq_cin_q    <= rq_cin_d;
      rq_opa_q    <= rq_opa_d;
      rq_opb_q    <= rq_opb_d;
      rq_split_q  <= rq_split_d;
      rq_gap_q    <= rq_gap_d;
      rq_late_q   <= rq_late_d;
      gap_cnt_q   <= gap_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      ce_q        <= ce_d;
      inp_valid_q <= inp_valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cmd_q       <= cmd_d;
      mode_q      <= mode_d;
      cin_q       <= cin_d;
    end
  end

  alu_rsp_capture #(.DW(DW)) u_capture (
    .CLK        (CLK),
    .RST        (RST),
    .capture_en (capture_en),
    .late_in    (rq_late_q),
    .res_in     (RES),
    .flags_in   ({COUT, OFLOW, G, E, L, ERR}),
    .res_out    (bus.rsp_res),
    .flags_out  (cap_flags),
    .late_out   (bus.rsp_late)
  );

  assign {bus.rsp_cout, bus.rsp_oflow, bus.rsp_g, bus.rsp_e, bus.rsp_l, bus.rsp_err} = cap_flags;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign CE            = ce_q;
  assign INP_VALID     = inp_valid_q;
  assign OPA           = opa_q;
  assign OPB           = opb_q;
  assign CMD           = cmd_q;
  assign MODE          = mode_q;
  assign CIN           = cin_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: directed requests, a behavioural ALU stub that only
// presents a valid result in the expected cycle, and a scoreboard monitor.
module tb_alu_op_issuer;

  localparam int DW = 8;
  localparam int CW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_op_issuer_if #(.DW(DW), .CW(CW)) bus ();

  logic          CE;
  logic [1:0]    INP_VALID;
  logic [DW-1:0] OPA, OPB;
  logic          CIN;
  logic [CW-1:0] CMD;
  logic          MODE;
  logic [DW+1:0] RES;
  logic          COUT, OFLOW, G, E, L, ERR;

  alu_op_issuer #(.DW(DW), .CW(CW), .RES_LAT(1), .MUL_LAT(3), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .bus(bus.slave),
    .CE(CE), .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB), .CIN(CIN), .CMD(CMD), .MODE(MODE),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
  );

  typedef struct packed {
    logic [9:0] res;
    logic cout, oflow, g, e, l, err, late;
  } rsp_t;

  typedef struct packed {
    logic       mode;
    logic [3:0] cmd;
    logic       cin;
    logic [7:0] opa, opb;
    logic [1:0] split;
    logic [4:0] gap;
    logic       inj;
    rsp_t       exp;
  } vec_t;

  typedef struct packed {
    rsp_t       exp;
    logic [1:0] split;
    logic [4:0] gap;
    logic [3:0] lat;
  } sb_t;

  int checks = 0;
  int failures = 0;
  sb_t sb_q[$];
  logic [1:0] act_trace[$];
  int rsp_done = 0;
  bit in_rsp = 0;
  logic cur_inj = 1'b0;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mode, input logic [3:0] cmd, input logic cin,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [1:0] split, input logic [4:0] gap, input logic inj,
                              input logic [9:0] res, input logic cout, input logic oflow,
                              input logic g, input logic e, input logic l, input logic err,
                              input logic late);
    vec_t v;
    v.mode = mode; v.cmd = cmd; v.cin = cin; v.opa = a; v.opb = b;
    v.split = split; v.gap = gap; v.inj = inj;
    v.exp = '{res: res, cout: cout, oflow: oflow, g: g, e: e, l: l, err: err, late: late};
    return v;
  endfunction

  function automatic logic [3:0] stub_lat(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 4'd3 : 4'd1;
  endfunction

  // Expected INP_VALID while CE is high, by position
  function automatic logic [1:0] exp_iv(input sb_t s, input int i);
    if (s.split == 2'b00 || s.split == 2'b11) return (i == 0) ? 2'b11 : 2'b00;
    if (i == 0) return s.split;
    if (i == int'(s.gap) + 1) return ~s.split;
    return 2'b00;
  endfunction

  function automatic int exp_len(input sb_t s);
    if (s.split == 2'b00 || s.split == 2'b11) return 1 + int'(s.lat);
    return int'(s.gap) + 2 + int'(s.lat);
  endfunction

  // Behavioural ALU: {res, cout, oflow, g, e, l, err}; flags it does not drive float
  function automatic logic [16:0] alu_fn(input logic mode, input logic [3:0] cmd, input logic cin,
                                         input logic [7:0] a, input logic [7:0] b, input logic inj);
    logic [9:0] r;
    logic [15:0] m;
    logic co, ov, gg, ee, ll, er;
    r = 'z; co = 1'bz; ov = 1'bz; gg = 1'bz; ee = 1'bz; ll = 1'bz;
    er = inj ? 1'b1 : 1'bz;
    m = '0;
    if (mode) begin
      case (cmd)
        4'd0: begin r = {2'b00, a} + {2'b00, b}; co = r[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
        4'd1: begin r = {2'b00, a} - {2'b00, b}; co = (a < b); ov = (a[7] != b[7]) && (r[7] != a[7]); end
        4'd2: begin r = {2'b00, a} + {2'b00, b} + {9'd0, cin}; co = r[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
        4'd8: begin
          if (a > b) gg = 1'b1;
          if (a == b) ee = 1'b1;
          if (a < b) ll = 1'b1;
        end
        4'd9: begin m = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1); r = m[9:0]; end
        4'd10: begin m = ({8'd0, a} << 1) * {8'd0, b}; r = m[9:0]; end
        default: r = '0;
      endcase
    end else begin
      case (cmd)
        4'd0: r = {2'b00, a & b};
        4'd2: r = {2'b00, a | b};
        default: r = {2'b00, a ^ b};
      endcase
    end
    return {r, co, ov, gg, ee, ll, er};
  endfunction

  logic [7:0] st_a, st_b;
  logic [3:0] st_cmd, st_cnt;
  logic       st_mode, st_cin, st_got_a, st_got_b;

  // ALU stub: collect operands, then count down to the result-valid cycle
  always @(posedge CLK) begin
    if (!RST) begin
      st_got_a <= 1'b0; st_got_b <= 1'b0; st_cnt <= '0;
    end else if (INP_VALID != 2'b00) begin
      if (INP_VALID[0]) st_a <= OPA;
      if (INP_VALID[1]) st_b <= OPB;
      st_cmd <= CMD; st_mode <= MODE; st_cin <= CIN;
      if ((st_got_a || INP_VALID[0]) && (st_got_b || INP_VALID[1])) begin
        st_cnt <= stub_lat(MODE, CMD);
        st_got_a <= 1'b0; st_got_b <= 1'b0;
      end else begin
        st_got_a <= st_got_a || INP_VALID[0];
        st_got_b <= st_got_b || INP_VALID[1];
      end
    end else if (st_cnt != 4'd0) begin
      st_cnt <= st_cnt - 4'd1;
    end
  end

  // Outside the result-valid cycle the stub shows all-ones garbage
  always_comb begin
    {RES, COUT, OFLOW, G, E, L, ERR} = '1;
    if (st_cnt == 4'd1) {RES, COUT, OFLOW, G, E, L, ERR} = alu_fn(st_mode, st_cmd, st_cin, st_a, st_b, cur_inj);
  end

  // Monitor: operand-phase trace and response fields against the scoreboard
  always @(negedge CLK) begin
    if (RST) begin
      if (CE) act_trace.push_back(INP_VALID);
      if (bus.rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp: actual=%h required=none", bus.rsp_res);
        end else begin
          if (!in_rsp) begin
            logic [63:0] ap, ep;
            ap = 64'(act_trace.size()); ep = 64'(exp_len(sb_q[0]));
            foreach (act_trace[i]) ap = {ap[61:0], act_trace[i]};
            for (int i = 0; i < exp_len(sb_q[0]); i++) ep = {ep[61:0], exp_iv(sb_q[0], i)};
            chk("inp_trace", ap, ep);
            act_trace.delete();
          end
          in_rsp = 1;
          chk("rsp_fields", 64'({bus.rsp_res, bus.rsp_cout, bus.rsp_oflow, bus.rsp_g, bus.rsp_e,
                                 bus.rsp_l, bus.rsp_err, bus.rsp_late}), 64'(sb_q[0].exp));
          chk("req_ready_in_resp", 64'(bus.req_ready), 64'(0));
          if (bus.rsp_ready) begin
            void'(sb_q.pop_front());
            rsp_done++;
            in_rsp = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input vec_t v);
    sb_t s;
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_wait", 64'(bus.req_ready), 64'(1));
    cur_inj = v.inj;
    bus.req_mode = v.mode; bus.req_cmd = v.cmd; bus.req_cin = v.cin;
    bus.req_opa = v.opa; bus.req_opb = v.opb; bus.req_split = v.split; bus.req_gap = v.gap;
    bus.req_valid = 1'b1;
    s.exp = v.exp; s.split = v.split; s.gap = v.gap; s.lat = stub_lat(v.mode, v.cmd);
    sb_q.push_back(s);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit bp);
    int start, n;
    start = rsp_done;
    if (bp) bus.rsp_ready = 1'b0;
    issue(v);
    if (bp) begin
      n = 0;
      while (!bus.rsp_valid && n < 100) begin tick(); n++; end
      chk("bp_rsp_valid_seen", 64'(bus.rsp_valid), 64'(1));
      repeat (5) tick();
      bus.rsp_ready = 1'b1;
    end
    n = 0;
    while (rsp_done == start && n < 200) begin tick(); n++; end
    if (rsp_done == start) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: actual=none required=response");
    end
    if (bp) begin
      chk("bp_rsp_valid_after", 64'(bus.rsp_valid), 64'(0));
      chk("bp_req_ready_after", 64'(bus.req_ready), 64'(1));
    end
  endtask

  initial begin
    bit saw_rsp;
    //            mode cmd  cin opa    opb    split gap  inj  res       co  ov  g   e   l   err late
    vecs[0]  = mk(1, 4'd0,  0, 8'h0A, 8'h05, 2'b00, 5'd0,  0, 10'h00F, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 4'd9,  0, 8'h03, 8'h04, 2'b01, 5'd2,  0, 10'h014, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 4'd0,  0, 8'hF0, 8'h3C, 2'b10, 5'd0,  0, 10'h030, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 4'd8,  0, 8'h07, 8'h07, 2'b01, 5'd17, 0, 10'h000, 0, 0, 0, 1, 0, 0, 1);
    vecs[4]  = mk(1, 4'd1,  0, 8'h20, 8'h05, 2'b10, 5'd3,  1, 10'h01B, 0, 0, 0, 0, 0, 1, 0);
    vecs[5]  = mk(1, 4'd2,  1, 8'hFF, 8'h01, 2'b10, 5'd16, 0, 10'h101, 1, 0, 0, 0, 0, 0, 1);
    vecs[6]  = mk(0, 4'd4,  0, 8'h55, 8'hFF, 2'b01, 5'd15, 0, 10'h0AA, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 4'd10, 0, 8'h03, 8'h05, 2'b00, 5'd0,  0, 10'h01E, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 4'd9,  0, 8'h0C, 8'h0A, 2'b00, 5'd0,  0, 10'h006, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 4'd0,  0, 8'h7F, 8'h01, 2'b11, 5'd9,  0, 10'h080, 0, 1, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 4'd2,  0, 8'h0F, 8'hA0, 2'b00, 5'd0,  0, 10'h0AF, 0, 0, 0, 0, 0, 0, 0);

    bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_mode = 1'b0; bus.req_cin = 1'b0;
    bus.req_opa = '0; bus.req_opb = '0; bus.req_split = '0; bus.req_gap = '0;
    bus.rsp_ready = 1'b1;
    RST = 1'b0;
    repeat (3) tick();

    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_ce", 64'(CE), 64'(0));
    chk("rst_inp_valid", 64'(INP_VALID), 64'(0));
    chk("rst_operands", 64'({OPA, OPB, CMD, MODE, CIN}), 64'(0));
    chk("rst_rsp_fields", 64'({bus.rsp_res, bus.rsp_cout, bus.rsp_oflow, bus.rsp_g, bus.rsp_e,
                               bus.rsp_l, bus.rsp_err, bus.rsp_late}), 64'(0));
    RST = 1'b1;
    tick();

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k == 4);

    // Reset while waiting out a long gap
    issue(mk(1, 4'd0, 0, 8'h11, 8'h22, 2'b01, 5'd8, 0, 10'h033, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tick();
    chk("gap_ce_before_rst", 64'({CE, INP_VALID}), 64'(3'b100));
    RST = 1'b0;
    tick();
    chk("midrst_inp_valid", 64'(INP_VALID), 64'(0));
    chk("midrst_ce", 64'(CE), 64'(0));
    chk("midrst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    sb_q.delete();
    act_trace.delete();
    in_rsp = 0;
    RST = 1'b1;
    saw_rsp = 0;
    repeat (15) begin
      tick();
      if (bus.rsp_valid || CE) saw_rsp = 1;
    end
    chk("midrst_no_activity", 64'(saw_rsp), 64'(0));
    run_vec(vecs[10], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
